// File: rtl/pd_axis_engine.sv
// pd_axis_engine: multi-axis PD term engine sharing one arithmetic slice across axes.
// Optional HIST_PRIME_EN: fill an axis's history with its first error so the first dterm is 0.
module pd_axis_engine #(
   parameter int NUM_AXES      = 3,
   parameter int IN_W          = 16,
   parameter int ERR_W         = 10,
   parameter int DDIFF_W       = 6,
   parameter int DTERM_GAIN    = 7,
   parameter int DTERM_W       = 12,
   parameter int D_QUEUE_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        vld,
   input  logic [NUM_AXES*IN_W-1:0]    act,
   input  logic [NUM_AXES*IN_W-1:0]    des,
   input  logic                        clr_hist,
   output logic                        rdy,
   output logic [NUM_AXES*ERR_W-1:0]   pterm,
   output logic [NUM_AXES*DTERM_W-1:0] dterm,
   output logic                        out_vld
);
   localparam int IW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
   localparam logic signed [IN_W:0] E_HI = {{(IN_W-ERR_W+2){1'b0}}, {(ERR_W-1){1'b1}}};
   localparam logic signed [IN_W:0] E_LO = {{(IN_W-ERR_W+2){1'b1}}, {(ERR_W-1){1'b0}}};
   localparam logic signed [ERR_W:0] D_HI = {{(ERR_W-DDIFF_W+2){1'b0}}, {(DDIFF_W-1){1'b1}}};
   localparam logic signed [ERR_W:0] D_LO = {{(ERR_W-DDIFF_W+2){1'b1}}, {(DDIFF_W-1){1'b0}}};
   localparam logic signed [DTERM_W-1:0] GAIN = DTERM_W'(DTERM_GAIN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t                      state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [NUM_AXES*IN_W-1:0]    act_q, act_d, des_q, des_d;
   logic [NUM_AXES*ERR_W-1:0]   pstg_q, pstg_d, pterm_q, pterm_d;
   logic [NUM_AXES*DTERM_W-1:0] dstg_q, dstg_d, dterm_q, dterm_d;
   logic                        out_vld_q, out_vld_d, rdy_q, rdy_d;
   logic signed [ERR_W-1:0]     hist_q [NUM_AXES][D_QUEUE_DEPTH];
   logic signed [ERR_W-1:0]     hist_d [NUM_AXES][D_QUEUE_DEPTH];
   logic signed [IN_W:0]        err_w;
   logic signed [ERR_W-1:0]     err_sat, prev, p_ax;
   logic signed [ERR_W:0]       dd_w;
   logic signed [DDIFF_W-1:0]   dd_sat;
   logic signed [DTERM_W-1:0]   d_ax;
   logic [IN_W-1:0]             act_i, des_i;
   logic                        fill;
`ifdef HIST_PRIME_EN
   logic [NUM_AXES-1:0]         primed_q, primed_d;
   assign fill = ~primed_q[idx_q];
`else
   assign fill = 1'b0;
`endif
   assign act_i   = act_q[idx_q*IN_W +: IN_W];
   assign des_i   = des_q[idx_q*IN_W +: IN_W];
   assign err_w   = $signed({act_i[IN_W-1], act_i}) - $signed({des_i[IN_W-1], des_i});
   assign err_sat = (err_w > E_HI) ? ERR_W'(E_HI) : (err_w < E_LO) ? ERR_W'(E_LO) : ERR_W'(err_w);
   assign p_ax    = (err_sat >>> 1) + (err_sat >>> 3);
   // An unprimed axis compares against itself, giving a zero derivative kick.
   assign prev    = fill ? err_sat : hist_q[idx_q][D_QUEUE_DEPTH-1];
   assign dd_w    = $signed({err_sat[ERR_W-1], err_sat}) - $signed({prev[ERR_W-1], prev});
   assign dd_sat  = (dd_w > D_HI) ? DDIFF_W'(D_HI) : (dd_w < D_LO) ? DDIFF_W'(D_LO) : DDIFF_W'(dd_w);
   assign d_ax    = DTERM_W'(dd_sat) * GAIN;
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      act_d     = act_q;
      des_d     = des_q;
      pstg_d    = pstg_q;
      dstg_d    = dstg_q;
      pterm_d   = pterm_q;
      dterm_d   = dterm_q;
      hist_d    = hist_q;
      out_vld_d = 1'b0;
`ifdef HIST_PRIME_EN
      primed_d  = primed_q;
`endif
      case (state_q)
         IDLE: begin
            if (clr_hist) begin
               for (int a = 0; a < NUM_AXES; a++)
                  for (int j = 0; j < D_QUEUE_DEPTH; j++) hist_d[a][j] = '0;
`ifdef HIST_PRIME_EN
               primed_d = '0;
`endif
            end
            if (vld) begin
               act_d   = act;
               des_d   = des;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            pstg_d[idx_q*ERR_W +: ERR_W]     = p_ax;
            dstg_d[idx_q*DTERM_W +: DTERM_W] = d_ax;
            for (int j = D_QUEUE_DEPTH-1; j > 0; j--)
               hist_d[idx_q][j] = fill ? err_sat : hist_q[idx_q][j-1];
            hist_d[idx_q][0] = err_sat;
`ifdef HIST_PRIME_EN
            primed_d[idx_q] = 1'b1;
`endif
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == IW'(NUM_AXES-1)) ? DONE : CALC;
         end
         DONE: begin
            pterm_d   = pstg_q;
            dterm_d   = dstg_q;
            out_vld_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         act_q     <= '0;
         des_q     <= '0;
         pstg_q    <= '0;
         dstg_q    <= '0;
         pterm_q   <= '0;
         dterm_q   <= '0;
         out_vld_q <= 1'b0;
         rdy_q     <= 1'b1;
         for (int a = 0; a < NUM_AXES; a++)
            for (int j = 0; j < D_QUEUE_DEPTH; j++) hist_q[a][j] <= '0;
`ifdef HIST_PRIME_EN
         primed_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         act_q     <= act_d;
         des_q     <= des_d;
         pstg_q    <= pstg_d;
         dstg_q    <= dstg_d;
         pterm_q   <= pterm_d;
         dterm_q   <= dterm_d;
         out_vld_q <= out_vld_d;
         rdy_q     <= rdy_d;
         hist_q    <= hist_d;
`ifdef HIST_PRIME_EN
         primed_q  <= primed_d;
`endif
      end
   end
   assign rdy     = rdy_q;
   assign pterm   = pterm_q;
   assign dterm   = dterm_q;
   assign out_vld = out_vld_q;
endmodule

// File: tb/tb_pd_axis_engine.sv
// tb_pd_axis_engine: directed table-driven checks of pd_axis_engine with default parameters.
module tb_pd_axis_engine;
`ifdef HIST_PRIME_EN
   localparam bit PR = 1'b1;
`else
   localparam bit PR = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst, vld, clr_hist, rdy, out_vld;
   logic [47:0] act, des;
   logic [29:0] pterm;
   logic [35:0] dterm;
   int          total = 0, bad = 0;
   typedef struct {
      bit          rs;
      bit          clr;
      logic [15:0] a0, a1;
      logic [9:0]  p0, p1;
      logic [11:0] d0, d1;
   } vec_t;
   vec_t tv [11];
   pd_axis_engine dut (
      .clk(clk), .rst(rst), .vld(vld), .act(act), .des(des), .clr_hist(clr_hist),
      .rdy(rdy), .pterm(pterm), .dterm(dterm), .out_vld(out_vld)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic send(input logic [15:0] a0, input logic [15:0] a1, input logic c, output int lat);
      @(negedge clk);
      act = {16'h0, a1, a0};
      vld = 1'b1;
      clr_hist = c;
      @(posedge clk);
      #1;
      vld = 1'b0;
      clr_hist = 1'b0;
      lat = 0;
      while (!out_vld && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int lat, pulses;
      tv[0]  = '{1, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      tv[1]  = '{0, 0, 16'h0080, 16'h0000, 10'h050, 10'h000, 12'h0D9, 12'h000};
      tv[2]  = '{0, 0, 16'h0220, 16'h0000, 10'h13E, 10'h000, 12'h0D9, 12'h000};
      tv[3]  = '{1, 0, 16'h0000, 16'hFFF0, 10'h000, 10'h3F6, 12'h000, PR ? 12'h000 : 12'hF90};
      tv[4]  = '{1, 0, 16'h0000, 16'hFDE0, 10'h000, 10'h2C0, 12'h000, PR ? 12'h000 : 12'hF20};
      tv[5]  = '{1, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      tv[6]  = '{0, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      tv[7]  = '{0, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      tv[8]  = '{0, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      tv[9]  = '{0, 0, 16'h0010, 16'h0000, 10'h00A, 10'h000, 12'h000, 12'h000};
      tv[10] = '{0, 1, 16'h0010, 16'h0000, 10'h00A, 10'h000, PR ? 12'h000 : 12'h070, 12'h000};
      rst = 1'b1;
      vld = 1'b0;
      clr_hist = 1'b0;
      act = '0;
      des = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_pterm", 64'(pterm), 64'h0);
      chk("rst_dterm", 64'(dterm), 64'h0);
      chk("rst_rdy", 64'(rdy), 64'h1);
      chk("rst_out_vld", 64'(out_vld), 64'h0);
      for (int i = 0; i < 11; i++) begin
         if (tv[i].rs) do_reset();
         send(tv[i].a0, tv[i].a1, tv[i].clr, lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("v%0d_pterm", i), 64'(pterm), 64'({10'h0, tv[i].p1, tv[i].p0}));
         chk($sformatf("v%0d_dterm", i), 64'(dterm), 64'({12'h0, tv[i].d1, tv[i].d0}));
      end
      do_reset();
      @(negedge clk);
      act = {32'h0, 16'h0010};
      vld = 1'b1;
      @(negedge clk);
      act = {32'h0, 16'h0080};
      @(negedge clk);
      vld = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (out_vld) pulses++;
      end
      chk("busy_vld_pulses", 64'(pulses), 64'd1);
      chk("busy_vld_pterm", 64'(pterm), 64'h00A);
      chk("busy_vld_dterm", 64'(dterm), PR ? 64'h0 : 64'h070);
      @(negedge clk);
      act = {32'h0, 16'h0080};
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_vld) pulses++;
      end
      chk("midrst_pulses", 64'(pulses), 64'd0);
      chk("midrst_pterm", 64'(pterm), 64'h0);
      chk("midrst_dterm", 64'(dterm), 64'h0);
      chk("midrst_rdy", 64'(rdy), 64'h1);
      send(16'h0010, 16'h0000, 1'b0, lat);
      chk("midrst_next_latency", 64'(lat), 64'd4);
      chk("midrst_next_dterm", 64'(dterm), PR ? 64'h0 : 64'h070);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
